// File: rtl/axistream_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axistream_arbiter_pkg
//
// Shared types for the packet-aware AXI-Stream arbiter and its skid stage.
//
// Contents:
//   arbState_e    - arbiter FSM states (IDLE, GRANT)
//   beat_t        - one AXI-Stream beat plus the index of the producing port
//   portIdxWidth  - width of a port index for a given number of ports
//
// beat_t is sized for the widest supported configuration (16 ports, 64-bit
// tdata). Narrower instances zero-fill the unused upper bits, and synthesis
// trims them away because they never change.
// ---------------------------------------------------------------------------
package axistream_arbiter_pkg;

  localparam int MAX_PORTS      = 16;
  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_IDX_WIDTH  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arbState_e;

  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0] tdata;
    logic                      tid;
    logic                      tdest;
    logic                      tlast;
    logic                      tkeep;
    logic                      terr;
    logic [MAX_IDX_WIDTH-1:0]  tsrc;
  } beat_t;

  // A port index is never narrower than one bit, even for two ports.
  function automatic int portIdxWidth(input int numPorts);
    return (numPorts <= 2) ? 1 : $clog2(numPorts);
  endfunction

endpackage

// File: rtl/axistream_skid.sv
// ---------------------------------------------------------------------------
// axistream_skid
//
// Two-entry register slice carrying one beat_t per entry. The output comes
// straight from the head register, and in_ready_o is registered, so there is
// no combinational path from out_ready_i back to in_ready_o.
//
// Ports:
//   clk          - clock, rising edge
//   rst          - synchronous active-high reset, empties both entries
//   in_valid_i   - upstream beat is valid
//   in_ready_o   - registered "not full"; low only when both entries hold data
//   in_beat_i    - upstream beat
//   out_valid_o  - head entry holds data
//   out_ready_i  - downstream accepts the head entry
//   out_beat_o   - head entry
// ---------------------------------------------------------------------------
module axistream_skid
  import axistream_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid_i,
  output logic  in_ready_o,
  input  beat_t in_beat_i,
  output logic  out_valid_o,
  input  logic  out_ready_i,
  output beat_t out_beat_o
);

  logic [1:0] count_q, count_d;
  beat_t      head_q, head_d;
  beat_t      tail_q, tail_d;
  logic       notFull_q, notFull_d;
  logic       push;
  logic       pop;

  assign push = in_valid_i & notFull_q;
  assign pop  = (count_q != 2'd0) & out_ready_i;

  // Occupancy update. The head always holds the oldest beat; the tail only
  // fills when a push arrives while the head is occupied and not leaving.
  // A push and pop with one entry held replaces the head in place.
  // "Not full" is derived from the next-state occupancy so it can be
  // registered and still be exact in the following cycle.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = in_beat_i;
        end else begin
          tail_d = in_beat_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in_beat_i;
        end else begin
          head_d = tail_q;
          tail_d = in_beat_i;
        end
      end
      default: begin
      end
    endcase
    notFull_d = (count_d != 2'd2);
  end

  // Storage registers. Reset clears the payload as well so the output bus
  // reads as zero until the first beat arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
      notFull_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      notFull_q <= notFull_d;
    end
  end

  assign in_ready_o  = notFull_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_beat_o  = head_q;

endmodule

// File: rtl/axistream_arbiter.sv
// ---------------------------------------------------------------------------
// axistream_arbiter
//
// Packet-aware round-robin arbiter merging NUM_PORTS AXI-Stream inputs onto
// one output. A grant is held from the first beat of a packet until its tlast
// beat is accepted, so packets are never interleaved. Each new arbitration
// costs one IDLE cycle. A two-entry skid stage drives the output.
//
// Parameters:
//   NUM_PORTS  - number of slave inputs, 2..16
//   DATA_WIDTH - tdata width, 1..64
//
// Ports:
//   clk, rst                      - clock and synchronous active-high reset
//   s_axis_tvalid/tready          - per-port handshake, at most one ready high
//   s_axis_tid/tdest/tlast/tkeep/terr - per-port sideband, bit i is port i
//   s_axis_tdata                  - port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_tvalid/tready          - output handshake
//   m_axis_tid/tdest/tlast/tkeep/terr/tdata - output beat
//   m_axis_tsrc                   - index of the port that produced the beat
// ---------------------------------------------------------------------------
module axistream_arbiter
  import axistream_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS  = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int IDX_W      = portIdxWidth(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS-1:0]            s_axis_tid,
  input  logic [NUM_PORTS-1:0]            s_axis_tdest,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  input  logic [NUM_PORTS-1:0]            s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]            s_axis_terr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tid,
  output logic                            m_axis_tdest,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tkeep,
  output logic                            m_axis_terr,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [IDX_W-1:0]                m_axis_tsrc
);

  arbState_e        state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] lastGrant_q, lastGrant_d;

  logic             rrFound;
  logic [IDX_W-1:0] rrSel;

  logic             skidInValid;
  logic             skidNotFull;
  logic             accept;
  beat_t            inBeat;
  beat_t            headBeat;
  logic             unusedHeadBits;

  logic [DATA_WIDTH-1:0] portData [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_portData
    assign portData[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: the first requesting port strictly after the last
  // granted one, wrapping. The last-granted port itself is checked last.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] candIdx;
    rrFound = 1'b0;
    rrSel   = '0;
    cand    = 0;
    candIdx = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = int'(lastGrant_q) + k;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      candIdx = IDX_W'(cand);
      if (!rrFound && s_axis_tvalid[candIdx]) begin
        rrFound = 1'b1;
        rrSel   = candIdx;
      end
    end
  end

  assign skidInValid = (state_q == GRANT) & s_axis_tvalid[grant_q];
  assign accept      = skidInValid & skidNotFull;

  // FSM next state. The grant is held through tvalid gaps; only an accepted
  // tlast beat releases it and records the port for the next search.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    case (state_q)
      IDLE: begin
        if (rrFound) begin
          grant_d = rrSel;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (accept && s_axis_tlast[grant_q]) begin
          lastGrant_d = grant_q;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last_grant resets to the top port so that port 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      lastGrant_q <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  // Only the granted port sees ready, and only while the skid stage has room.
  always_comb begin
    s_axis_tready = '0;
    if (state_q == GRANT) begin
      s_axis_tready[grant_q] = skidNotFull;
    end
  end

  // Input mux: the granted port's beat, tagged with its index.
  always_comb begin
    inBeat                   = '0;
    inBeat.tdata[DATA_WIDTH-1:0] = portData[grant_q];
    inBeat.tid               = s_axis_tid[grant_q];
    inBeat.tdest             = s_axis_tdest[grant_q];
    inBeat.tlast             = s_axis_tlast[grant_q];
    inBeat.tkeep             = s_axis_tkeep[grant_q];
    inBeat.terr              = s_axis_terr[grant_q];
    inBeat.tsrc[IDX_W-1:0]   = grant_q;
  end

  axistream_skid u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (skidInValid),
    .in_ready_o  (skidNotFull),
    .in_beat_i   (inBeat),
    .out_valid_o (m_axis_tvalid),
    .out_ready_i (m_axis_tready),
    .out_beat_o  (headBeat)
  );

  assign m_axis_tdata = headBeat.tdata[DATA_WIDTH-1:0];
  assign m_axis_tid   = headBeat.tid;
  assign m_axis_tdest = headBeat.tdest;
  assign m_axis_tlast = headBeat.tlast;
  assign m_axis_tkeep = headBeat.tkeep;
  assign m_axis_terr  = headBeat.terr;
  assign m_axis_tsrc  = headBeat.tsrc[IDX_W-1:0];

  // Upper bits of the wide beat fields are constant zero in this instance.
  assign unusedHeadBits = ^{headBeat.tdata, headBeat.tsrc};

endmodule

// File: tb/tb_axistream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axistream_arbiter
//
// Directed bench for axistream_arbiter (4 ports, 8-bit data). Per-port packet
// lists feed the inputs and advance when a beat is handshaken; every output
// handshake is logged with its cycle number and checked against hand-computed
// expectations.
// ---------------------------------------------------------------------------
module tb_axistream_arbiter;

  localparam int NP = 4;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [NP-1:0] s_tvalid, s_tready, s_tid, s_tdest, s_tlast, s_tkeep, s_terr;
  logic [NP*DW-1:0] s_tdata;
  logic          m_tvalid, m_tready, m_tid, m_tdest, m_tlast, m_tkeep, m_terr;
  logic [DW-1:0] m_tdata;
  logic [1:0]    m_tsrc;

  typedef struct {
    logic [7:0] data;
    logic [1:0] src;
    logic [4:0] sb;
    int         cyc;
  } logEntry_t;

  logEntry_t outLog[$];

  logic [7:0] srcData [NP][16];
  logic       srcLast [NP][16];
  logic       srcErr  [NP][16];
  int         srcLen  [NP];
  int         srcPos  [NP];
  logic       srcHold [NP];

  int assertCount;
  int failCount;
  int cyc;

  axistream_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tid    (s_tid),
    .s_axis_tdest  (s_tdest),
    .s_axis_tlast  (s_tlast),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_terr   (s_terr),
    .s_axis_tdata  (s_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tid    (m_tid),
    .m_axis_tdest  (m_tdest),
    .m_axis_tlast  (m_tlast),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_terr   (m_terr),
    .m_axis_tdata  (m_tdata),
    .m_axis_tsrc   (m_tsrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sideband is derived from the data byte so every beat carries a distinct
  // pattern: {tlast, terr, tid=d[0], tdest=d[1], tkeep=~d[2]}.
  function automatic logic [4:0] sbOf(input logic [7:0] d, input logic last,
                                      input logic err);
    return {last, err, d[0], d[1], ~d[2]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearSources();
    for (int p = 0; p < NP; p++) begin
      srcLen[p]  = 0;
      srcPos[p]  = 0;
      srcHold[p] = 1'b0;
    end
  endtask

  task automatic loadBeat(input int p, input logic [7:0] d, input logic last,
                          input logic err);
    srcData[p][srcLen[p]] = d;
    srcLast[p][srcLen[p]] = last;
    srcErr[p][srcLen[p]]  = err;
    srcLen[p]++;
  endtask

  task automatic driveSources();
    logic [7:0] d;
    for (int p = 0; p < NP; p++) begin
      if (!srcHold[p] && srcPos[p] < srcLen[p]) begin
        d                  = srcData[p][srcPos[p]];
        s_tvalid[p]        = 1'b1;
        s_tdata[p*DW +: DW] = d;
        s_tlast[p]         = srcLast[p][srcPos[p]];
        s_terr[p]          = srcErr[p][srcPos[p]];
        s_tid[p]           = d[0];
        s_tdest[p]         = d[1];
        s_tkeep[p]         = ~d[2];
      end else begin
        s_tvalid[p]        = 1'b0;
        s_tdata[p*DW +: DW] = '0;
        s_tlast[p]         = 1'b0;
        s_terr[p]          = 1'b0;
        s_tid[p]           = 1'b0;
        s_tdest[p]         = 1'b0;
        s_tkeep[p]         = 1'b0;
      end
    end
  endtask

  // One clock cycle: note handshakes seen in the current cycle, step past the
  // edge, advance the sources and re-drive them 1 time unit after the edge.
  task automatic applyStimulus();
    logic [NP-1:0] acc;
    logEntry_t     entry;
    acc = s_tvalid & s_tready;
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      entry.data = m_tdata;
      entry.src  = m_tsrc;
      entry.sb   = {m_tlast, m_terr, m_tid, m_tdest, m_tkeep};
      entry.cyc  = cyc;
      outLog.push_back(entry);
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        if (acc[p] === 1'b1) srcPos[p]++;
      end
    end
    cyc++;
    driveSources();
  endtask

  task automatic doReset();
    rst      = 1'b1;
    m_tready = 1'b1;
    clearSources();
    driveSources();
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    outLog.delete();
    cyc = 0;
  endtask

  task automatic checkBeat(input string tag, input int idx, input logic [7:0] expData,
                           input logic [1:0] expSrc, input logic expLast,
                           input logic expErr, input int expCyc);
    if (idx < outLog.size()) begin
      checkOutput($sformatf("%s_data%0d", tag, idx), outLog[idx].data, expData);
      checkOutput($sformatf("%s_src%0d", tag, idx), outLog[idx].src, expSrc);
      checkOutput($sformatf("%s_sb%0d", tag, idx), outLog[idx].sb,
                  sbOf(expData, expLast, expErr));
      if (expCyc >= 0) begin
        checkOutput($sformatf("%s_cyc%0d", tag, idx), outLog[idx].cyc, expCyc);
      end
    end
  endtask

  initial begin
    int pkt, port, j;
    assertCount = 0;
    failCount   = 0;
    cyc         = 0;
    rst         = 1'b1;
    m_tready    = 1'b1;
    clearSources();
    driveSources();

    // Reset state
    doReset();
    checkOutput("rst_tready", s_tready, 4'b0000);
    checkOutput("rst_mvalid", m_tvalid, 1'b0);
    checkOutput("rst_tdata", m_tdata, 8'h00);
    checkOutput("rst_tsrc", m_tsrc, 2'd0);
    checkOutput("rst_sideband", {m_tlast, m_terr, m_tid, m_tdest, m_tkeep}, 5'b0);

    // Single 3-beat packet on port 2
    $display("[TB] single packet on port 2");
    loadBeat(2, 8'h11, 1'b0, 1'b0);
    loadBeat(2, 8'h22, 1'b0, 1'b0);
    loadBeat(2, 8'h33, 1'b1, 1'b0);
    driveSources();
    checkOutput("t1_c0_tready", s_tready, 4'b0000);
    applyStimulus();
    checkOutput("t1_c1_tready", s_tready, 4'b0100);
    checkOutput("t1_c1_mvalid", m_tvalid, 1'b0);
    applyStimulus();
    checkOutput("t1_c2_mvalid", m_tvalid, 1'b1);
    checkOutput("t1_c2_tdata", m_tdata, 8'h11);
    checkOutput("t1_c2_tsrc", m_tsrc, 2'd2);
    checkOutput("t1_c2_tlast", m_tlast, 1'b0);
    applyStimulus();
    checkOutput("t1_c3_tdata", m_tdata, 8'h22);
    checkOutput("t1_c3_tlast", m_tlast, 1'b0);
    applyStimulus();
    checkOutput("t1_c4_tdata", m_tdata, 8'h33);
    checkOutput("t1_c4_tlast", m_tlast, 1'b1);
    checkOutput("t1_c4_tsrc", m_tsrc, 2'd2);
    checkOutput("t1_c4_tready", s_tready, 4'b0000);
    applyStimulus();
    checkOutput("t1_c5_mvalid", m_tvalid, 1'b0);

    // All ports sending two 2-beat packets each
    $display("[TB] round robin over all ports");
    doReset();
    for (int p = 0; p < NP; p++) begin
      for (int b = 0; b < 4; b++) begin
        loadBeat(p, 8'(p * 16 + b), 1'(b % 2), 1'b0);
      end
    end
    driveSources();
    repeat (27) applyStimulus();
    checkOutput("t2_count", outLog.size(), 16);
    for (int i = 0; i < 16; i++) begin
      pkt  = i / 2;
      port = pkt % 4;
      j    = (pkt / 4) * 2 + (i % 2);
      checkBeat("t2", i, 8'(port * 16 + j), 2'(port), 1'(i % 2), 1'b0,
                2 + 3 * pkt + (i % 2));
    end

    // Port 1 stalls mid-packet while port 0 requests
    $display("[TB] grant held across tvalid gap");
    doReset();
    loadBeat(1, 8'h41, 1'b0, 1'b0);
    loadBeat(1, 8'h42, 1'b0, 1'b0);
    loadBeat(1, 8'h43, 1'b1, 1'b0);
    driveSources();
    checkOutput("t3_c0_tready", s_tready, 4'b0000);
    applyStimulus();
    checkOutput("t3_c1_tready", s_tready, 4'b0010);
    applyStimulus();
    srcHold[1] = 1'b1;
    loadBeat(0, 8'h51, 1'b1, 1'b0);
    driveSources();
    checkOutput("t3_c2_tready", s_tready, 4'b0010);
    applyStimulus();
    checkOutput("t3_c3_tready", s_tready, 4'b0010);
    applyStimulus();
    checkOutput("t3_c4_tready", s_tready, 4'b0010);
    applyStimulus();
    srcHold[1] = 1'b0;
    driveSources();
    checkOutput("t3_c5_tready", s_tready, 4'b0010);
    applyStimulus();
    checkOutput("t3_c6_tready", s_tready, 4'b0010);
    applyStimulus();
    checkOutput("t3_c7_tready", s_tready, 4'b0000);
    applyStimulus();
    checkOutput("t3_c8_tready", s_tready, 4'b0001);
    repeat (4) applyStimulus();
    checkOutput("t3_count", outLog.size(), 4);
    checkBeat("t3", 0, 8'h41, 2'd1, 1'b0, 1'b0, -1);
    checkBeat("t3", 1, 8'h42, 2'd1, 1'b0, 1'b0, -1);
    checkBeat("t3", 2, 8'h43, 2'd1, 1'b1, 1'b0, -1);
    checkBeat("t3", 3, 8'h51, 2'd0, 1'b1, 1'b0, 9);

    // Downstream backpressure for 5 cycles in an 8-beat packet
    $display("[TB] backpressure");
    doReset();
    for (int b = 1; b <= 8; b++) begin
      loadBeat(0, 8'(b), (b == 8), 1'b0);
    end
    driveSources();
    applyStimulus();
    applyStimulus();
    applyStimulus();
    m_tready = 1'b0;
    checkOutput("t4_c3_tready", s_tready, 4'b0001);
    checkOutput("t4_c3_accepted", srcPos[0], 2);
    applyStimulus();
    checkOutput("t4_c4_tready", s_tready, 4'b0000);
    checkOutput("t4_c4_accepted", srcPos[0], 3);
    applyStimulus();
    checkOutput("t4_c5_tready", s_tready, 4'b0000);
    applyStimulus();
    checkOutput("t4_c6_tready", s_tready, 4'b0000);
    applyStimulus();
    checkOutput("t4_c7_tready", s_tready, 4'b0000);
    applyStimulus();
    m_tready = 1'b1;
    checkOutput("t4_c8_tready", s_tready, 4'b0000);
    applyStimulus();
    checkOutput("t4_c9_tready", s_tready, 4'b0001);
    checkOutput("t4_c9_accepted", srcPos[0], 3);
    repeat (12) applyStimulus();
    checkOutput("t4_count", outLog.size(), 8);
    for (int i = 0; i < 8; i++) begin
      checkBeat("t4", i, 8'(i + 1), 2'd0, (i == 7), 1'b0, -1);
    end

    // Single-beat packets on ports 0 and 3, terr on port 3
    $display("[TB] single-beat packets with terr");
    doReset();
    loadBeat(0, 8'hA0, 1'b1, 1'b0);
    loadBeat(3, 8'hD3, 1'b1, 1'b1);
    driveSources();
    repeat (4) applyStimulus();
    checkOutput("t5_c4_mvalid", m_tvalid, 1'b1);
    checkOutput("t5_c4_tdata", m_tdata, 8'hD3);
    checkOutput("t5_c4_terr", m_terr, 1'b1);
    checkOutput("t5_c4_tsrc", m_tsrc, 2'd3);
    repeat (2) applyStimulus();
    checkOutput("t5_count", outLog.size(), 2);
    checkBeat("t5", 0, 8'hA0, 2'd0, 1'b1, 1'b0, 2);
    checkBeat("t5", 1, 8'hD3, 2'd3, 1'b1, 1'b1, 4);

    // Reset with two beats buffered, after port 1 has moved last_grant
    $display("[TB] reset mid-packet");
    doReset();
    loadBeat(1, 8'h61, 1'b1, 1'b0);
    driveSources();
    repeat (4) applyStimulus();
    m_tready = 1'b0;
    for (int b = 0; b < 6; b++) begin
      loadBeat(2, 8'(8'h71 + b), (b == 5), 1'b0);
    end
    driveSources();
    applyStimulus();
    checkOutput("t6_c1_tready", s_tready, 4'b0100);
    applyStimulus();
    applyStimulus();
    checkOutput("t6_c3_mvalid", m_tvalid, 1'b1);
    checkOutput("t6_c3_tready", s_tready, 4'b0000);
    checkOutput("t6_c3_tdata", m_tdata, 8'h71);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    clearSources();
    outLog.delete();
    cyc = 0;
    driveSources();
    checkOutput("t6_post_mvalid", m_tvalid, 1'b0);
    checkOutput("t6_post_tready", s_tready, 4'b0000);
    checkOutput("t6_post_tdata", m_tdata, 8'h00);
    m_tready = 1'b1;
    loadBeat(0, 8'h80, 1'b1, 1'b0);
    loadBeat(2, 8'h82, 1'b1, 1'b0);
    loadBeat(3, 8'h83, 1'b1, 1'b0);
    driveSources();
    repeat (10) applyStimulus();
    checkOutput("t6_count", outLog.size(), 3);
    checkBeat("t6", 0, 8'h80, 2'd0, 1'b1, 1'b0, 2);
    checkBeat("t6", 1, 8'h82, 2'd2, 1'b1, 1'b0, 4);
    checkBeat("t6", 2, 8'h83, 2'd3, 1'b1, 1'b0, 6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
